// File: rtl/wordle_pkg.sv
// Shared state encoding, key codes, score codes and word helpers for the
// Wordle guess sequencer.
package wordle_pkg;

    localparam int WORD_LEN    = 5;
    localparam int MAX_GUESSES = 6;
    localparam int LETTER_W    = 8;
    localparam int WORD_W      = WORD_LEN * LETTER_W;
    localparam int SCORE_W     = 2 * WORD_LEN;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        GREEN,
        YELLOW,
        REPORT,
        DONE
    } wordle_state_e;

    localparam logic [LETTER_W-1:0] KEY_BS    = 8'h08;
    localparam logic [LETTER_W-1:0] KEY_ENTER = 8'h0D;

    localparam logic [1:0] SCORE_GRAY   = 2'b00;
    localparam logic [1:0] SCORE_YELLOW = 2'b01;
    localparam logic [1:0] SCORE_GREEN  = 2'b10;

    localparam logic [2:0]         FULL_CURSOR = 3'(WORD_LEN);
    localparam logic [2:0]         LAST_ROW    = 3'(MAX_GUESSES - 1);
    localparam logic [2:0]         LAST_POS    = 3'(WORD_LEN - 1);
    localparam logic [SCORE_W-1:0] ALL_GREEN   = 10'h2AA;

    // Letter 0 sits in the most significant byte of a word.
    function automatic logic [LETTER_W-1:0] get_letter(input logic [WORD_W-1:0] w, input int i);
        return w[WORD_W-1-LETTER_W*i -: LETTER_W];
    endfunction

    function automatic logic [1:0] get_score(input logic [SCORE_W-1:0] s, input int i);
        return s[SCORE_W-1-2*i -: 2];
    endfunction

endpackage

// File: rtl/wordle_letter_match.sv
// Finds the lowest-index secret letter that equals the given letter and has
// not already been claimed by a green or earlier yellow.
module wordle_letter_match
    import wordle_pkg::*;
(
    input  logic [LETTER_W-1:0] letter,
    input  logic [WORD_W-1:0]   secret,
    input  logic [WORD_LEN-1:0] used,
    output logic                hit,
    output logic [WORD_LEN-1:0] onehot
);

    logic [WORD_LEN-1:0] cand;

    always_comb begin
        for (int j = 0; j < WORD_LEN; j++) begin
            cand[j] = !used[j] && (get_letter(secret, j) == letter);
        end
    end

    // x & -x isolates the lowest set bit, i.e. the lowest secret index.
    assign onehot = cand & (-cand);
    assign hit    = |cand;

endmodule

// File: rtl/wordle_guess_seq.sv
// One Wordle game: keystroke entry, per-letter scoring and win/lose tracking.
// Optional hard mode is enabled by defining WORDLE_HARD_MODE_EN.
module wordle_guess_seq
    import wordle_pkg::*;
(
    input  logic                Clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WORD_W-1:0]   secret_word,
    input  logic                key_valid,
    input  logic [LETTER_W-1:0] key_code,
    output logic                key_ready,
    output logic [WORD_W-1:0]   letters,
    output logic [2:0]          cursor,
    output logic [2:0]          guess_row,
    output logic                score_valid,
    output logic [SCORE_W-1:0]  score,
    input  logic                ack,
    output logic                busy,
    output logic                win,
    output logic                lose,
    output logic                reject,
    output wordle_state_e       state
);

    // Handshakes: a key transfers on a rising edge with key_valid && key_ready;
    // the score is offered with score_valid held until an edge with ack high.
    wordle_state_e        state_q, state_d;
    logic [WORD_W-1:0]    secret_q, secret_d, letters_q, letters_d;
    logic [2:0]           cursor_q, cursor_d, row_q, row_d, pos_q, pos_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [WORD_LEN-1:0]  used_q, used_d;
    logic                 win_q, win_d, lose_q, lose_d;
    logic [LETTER_W-1:0]  key;
    logic                 is_letter;
    logic                 hit;
    logic [WORD_LEN-1:0]  onehot;

`ifdef WORDLE_HARD_MODE_EN
    logic [WORD_LEN-1:0]  gmask_q, gmask_d;
    logic [WORD_W-1:0]    glet_q, glet_d;
    logic                 reject_q, reject_d;
    logic                 conflict;

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (gmask_q[i] && (get_letter(letters_q, i) != get_letter(glet_q, i))) conflict = 1'b1;
        end
    end
`endif

    always_comb begin
        key = key_code;
        if (key_code >= "a" && key_code <= "z") key = key_code - 8'h20;
        is_letter = (key >= "A") && (key <= "Z");
    end

    wordle_letter_match u_match (
        .letter (get_letter(letters_q, int'(pos_q))),
        .secret (secret_q),
        .used   (used_q),
        .hit    (hit),
        .onehot (onehot)
    );

    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        letters_d = letters_q;
        cursor_d  = cursor_q;
        row_d     = row_q;
        pos_d     = pos_q;
        score_d   = score_q;
        used_d    = used_q;
        win_d     = win_q;
        lose_d    = lose_q;
`ifdef WORDLE_HARD_MODE_EN
        gmask_d   = gmask_q;
        glet_d    = glet_q;
        reject_d  = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = ENTRY;
                    secret_d  = secret_word;
                    letters_d = '0;
                    cursor_d  = '0;
                    row_d     = '0;
                    score_d   = '0;
                    used_d    = '0;
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
`ifdef WORDLE_HARD_MODE_EN
                    gmask_d   = '0;
                    glet_d    = '0;
`endif
                end
            end
            ENTRY: begin
                if (key_valid) begin
                    if (is_letter) begin
                        if (cursor_q != FULL_CURSOR) begin
                            for (int i = 0; i < WORD_LEN; i++) begin
                                if (cursor_q == 3'(i)) letters_d[WORD_W-1-LETTER_W*i -: LETTER_W] = key;
                            end
                            cursor_d = cursor_q + 3'd1;
                        end
                    end else if (key == KEY_BS) begin
                        if (cursor_q != 3'd0) begin
                            for (int i = 0; i < WORD_LEN; i++) begin
                                if (cursor_q == 3'(i + 1)) letters_d[WORD_W-1-LETTER_W*i -: LETTER_W] = '0;
                            end
                            cursor_d = cursor_q - 3'd1;
                        end
                    end else if (key == KEY_ENTER && cursor_q == FULL_CURSOR) begin
`ifdef WORDLE_HARD_MODE_EN
                        if (conflict) reject_d = 1'b1;
                        else          state_d  = GREEN;
`else
                        state_d = GREEN;
`endif
                    end
                end
            end
            GREEN: begin
                for (int i = 0; i < WORD_LEN; i++) begin
                    if (get_letter(letters_q, i) == get_letter(secret_q, i)) begin
                        score_d[SCORE_W-1-2*i -: 2] = SCORE_GREEN;
                        used_d[i] = 1'b1;
`ifdef WORDLE_HARD_MODE_EN
                        gmask_d[i] = 1'b1;
                        glet_d[WORD_W-1-LETTER_W*i -: LETTER_W] = get_letter(letters_q, i);
`endif
                    end else begin
                        score_d[SCORE_W-1-2*i -: 2] = SCORE_GRAY;
                    end
                end
                pos_d   = '0;
                state_d = YELLOW;
            end
            YELLOW: begin
                if (get_score(score_q, int'(pos_q)) != SCORE_GREEN && hit) begin
                    for (int i = 0; i < WORD_LEN; i++) begin
                        if (pos_q == 3'(i)) score_d[SCORE_W-1-2*i -: 2] = SCORE_YELLOW;
                    end
                    used_d = used_q | onehot;
                end
                if (pos_q == LAST_POS) state_d = REPORT;
                else                   pos_d   = pos_q + 3'd1;
            end
            REPORT: begin
                if (ack) begin
                    if (score_q == ALL_GREEN) begin
                        state_d = DONE;
                        win_d   = 1'b1;
                    end else if (row_q == LAST_ROW) begin
                        state_d = DONE;
                        lose_d  = 1'b1;
                    end else begin
                        state_d   = ENTRY;
                        row_d     = row_q + 3'd1;
                        cursor_d  = '0;
                        letters_d = '0;
                        score_d   = '0;
                        used_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            secret_q  <= '0;
            letters_q <= '0;
            cursor_q  <= '0;
            row_q     <= '0;
            pos_q     <= '0;
            score_q   <= '0;
            used_q    <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
`ifdef WORDLE_HARD_MODE_EN
            gmask_q   <= '0;
            glet_q    <= '0;
            reject_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            secret_q  <= secret_d;
            letters_q <= letters_d;
            cursor_q  <= cursor_d;
            row_q     <= row_d;
            pos_q     <= pos_d;
            score_q   <= score_d;
            used_q    <= used_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
`ifdef WORDLE_HARD_MODE_EN
            gmask_q   <= gmask_d;
            glet_q    <= glet_d;
            reject_q  <= reject_d;
`endif
        end
    end

    assign key_ready   = (state_q == ENTRY);
    assign busy        = (state_q == GREEN) || (state_q == YELLOW);
    assign score_valid = (state_q == REPORT);
    assign letters     = letters_q;
    assign cursor      = cursor_q;
    assign guess_row   = row_q;
    assign score       = score_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign state       = state_q;
`ifdef WORDLE_HARD_MODE_EN
    assign reject      = reject_q;
`else
    assign reject      = 1'b0;
`endif

endmodule

// File: tb/tb_wordle_guess_seq.sv
// Self-checking bench for wordle_guess_seq: editing table, scripted games,
// randomized games against a letter-count scoring model, reset mid-scoring.
module tb_wordle_guess_seq;
    import wordle_pkg::*;

    logic          Clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [39:0]   secret_word = '0;
    logic          key_valid = 1'b0;
    logic [7:0]    key_code = '0;
    logic          ack = 1'b0;
    logic          key_ready, score_valid, busy, win, lose, reject;
    logic [39:0]   letters;
    logic [2:0]    cursor, guess_row;
    logic [9:0]    score;
    wordle_state_e state;

    wordle_guess_seq dut (
        .Clk(Clk), .reset(reset), .start(start), .secret_word(secret_word),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .letters(letters), .cursor(cursor), .guess_row(guess_row),
        .score_valid(score_valid), .score(score), .ack(ack), .busy(busy),
        .win(win), .lose(lose), .reject(reject), .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [39:0] m_secret;
    int          m_row;
    logic [4:0]  m_gmask;
    logic [39:0] m_glet;
    string       alpha = "ROBTAESL";

    typedef struct {
        logic [7:0]  key;
        logic [2:0]  exp_cursor;
        logic [39:0] exp_letters;
    } edit_vec_t;

    edit_vec_t tbl [14];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_game(input logic [39:0] s);
        secret_word = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_secret = s;
        m_row = 0;
        m_gmask = '0;
        m_glet = '0;
    endtask

    task automatic press(input logic [7:0] k);
        key_valid = 1'b1;
        key_code = k;
        tick();
        key_valid = 1'b0;
        key_code = '0;
    endtask

    task automatic type_word(input logic [39:0] w);
        logic [7:0] k;
        for (int i = 0; i < 5; i++) begin
            k = w[39-8*i -: 8];
            if ($urandom_range(0, 1) == 1) k = k + 8'h20;
            press(k);
        end
    endtask

    // ---------------- reference model ----------------
    // Greens first, then each non-green guess letter takes one remaining
    // unmatched copy from the secret, left to right.
    function automatic logic [9:0] model_score(input logic [39:0] g, input logic [39:0] s);
        int         cnt [256];
        logic [9:0] r;
        logic [7:0] gl, sl;
        r = '0;
        for (int c = 0; c < 256; c++) cnt[c] = 0;
        for (int i = 0; i < 5; i++) begin
            gl = g[39-8*i -: 8];
            sl = s[39-8*i -: 8];
            if (gl == sl) r[9-2*i -: 2] = 2'b10;
            else cnt[sl]++;
        end
        for (int i = 0; i < 5; i++) begin
            gl = g[39-8*i -: 8];
            if (r[9-2*i -: 2] != 2'b10 && cnt[gl] > 0) begin
                r[9-2*i -: 2] = 2'b01;
                cnt[gl]--;
            end
        end
        return r;
    endfunction

    function automatic logic [39:0] rand_word();
        logic [39:0] w;
        for (int i = 0; i < 5; i++) w[39-8*i -: 8] = alpha[$urandom_range(0, 7)];
`ifdef WORDLE_HARD_MODE_EN
        for (int i = 0; i < 5; i++) if (m_gmask[i]) w[39-8*i -: 8] = m_glet[39-8*i -: 8];
`endif
        return w;
    endfunction

    // ---------------- scoreboard: one full guess ----------------
    task automatic play_guess(input logic [39:0] g, output bit ended);
        logic [9:0] exp_s;
        int n;
        check("cursor_before_guess", 64'(cursor), 64'(0));
        check("row_before_guess", 64'(guess_row), 64'(m_row));
        type_word(g);
        check("cursor_full", 64'(cursor), 64'(5));
        press(KEY_ENTER);
        check("busy_after_enter", 64'(busy), 64'(1));
        check("no_reject", 64'(reject), 64'(0));
        n = 0;
        while (!score_valid && n < 20) begin
            tick();
            n++;
        end
        check("score_latency", 64'(n), 64'(6));
        exp_s = model_score(g, m_secret);
        check("score", 64'(score), 64'(exp_s));
        check("letters_in_report", 64'(letters), 64'(g));
        check("key_ready_report", 64'(key_ready), 64'(0));
        tick();
        check("score_valid_held", 64'(score_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            if (exp_s[9-2*i -: 2] == 2'b10) begin
                m_gmask[i] = 1'b1;
                m_glet[39-8*i -: 8] = g[39-8*i -: 8];
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (exp_s == 10'h2AA) begin
            check("win", 64'(win), 64'(1));
            check("win_lose", 64'(lose), 64'(0));
            check("win_state", 64'(state), 64'(DONE));
            check("win_row", 64'(guess_row), 64'(m_row));
            ended = 1'b1;
        end else if (m_row == 5) begin
            check("lose", 64'(lose), 64'(1));
            check("lose_win", 64'(win), 64'(0));
            check("lose_state", 64'(state), 64'(DONE));
            ended = 1'b1;
        end else begin
            m_row++;
            check("next_state", 64'(state), 64'(ENTRY));
            check("next_row", 64'(guess_row), 64'(m_row));
            check("next_letters", 64'(letters), 64'(0));
            check("next_score", 64'(score), 64'(0));
            ended = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ended;
        logic [39:0] gw;
        int          guesses;

        tbl[0]  = '{8'h41, 3'd1, {"A", 32'h0}};
        tbl[1]  = '{8'h42, 3'd2, {"AB", 24'h0}};
        tbl[2]  = '{KEY_BS, 3'd1, {"A", 32'h0}};
        tbl[3]  = '{KEY_BS, 3'd0, 40'h0};
        tbl[4]  = '{KEY_BS, 3'd0, 40'h0};
        tbl[5]  = '{8'h78, 3'd1, {"X", 32'h0}};
        tbl[6]  = '{8'h31, 3'd1, {"X", 32'h0}};
        tbl[7]  = '{8'h63, 3'd2, {"XC", 24'h0}};
        tbl[8]  = '{8'h44, 3'd3, {"XCD", 16'h0}};
        tbl[9]  = '{8'h45, 3'd4, {"XCDE", 8'h0}};
        tbl[10] = '{KEY_ENTER, 3'd4, {"XCDE", 8'h0}};
        tbl[11] = '{8'h46, 3'd5, "XCDEF"};
        tbl[12] = '{8'h47, 3'd5, "XCDEF"};
        tbl[13] = '{8'hFF, 3'd5, "XCDEF"};

        do_reset();
        check("rst_state", 64'(state), 64'(IDLE));
        check("rst_key_ready", 64'(key_ready), 64'(0));
        check("rst_letters", 64'(letters), 64'(0));
        check("rst_cursor", 64'(cursor), 64'(0));
        check("rst_row", 64'(guess_row), 64'(0));
        check("rst_score_valid", 64'(score_valid), 64'(0));
        check("rst_score", 64'(score), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_win", 64'(win), 64'(0));
        check("rst_lose", 64'(lose), 64'(0));
        check("rst_reject", 64'(reject), 64'(0));

        // key_valid outside ENTRY is ignored
        press("A");
        check("idle_key_ignored", 64'(letters), 64'(0));

        start_game("ROBOT");
        check("start_state", 64'(state), 64'(ENTRY));
        check("start_key_ready", 64'(key_ready), 64'(1));

        for (int i = 0; i < 14; i++) begin
            press(tbl[i].key);
            check($sformatf("edit_cursor_%0d", i), 64'(cursor), 64'(tbl[i].exp_cursor));
            check($sformatf("edit_letters_%0d", i), 64'(letters), 64'(tbl[i].exp_letters));
            check($sformatf("edit_state_%0d", i), 64'(state), 64'(ENTRY));
        end

        // start is ignored while entering
        secret_word = "ZZZZZ";
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_entry_state", 64'(state), 64'(ENTRY));
        check("start_in_entry_cursor", 64'(cursor), 64'(5));
        repeat (5) press(KEY_BS);
        check("cleared_letters", 64'(letters), 64'(0));

        play_guess("TORSO", ended);
        play_guess("OOOOO", ended);
        for (int r = 2; r < 6; r++) begin
            do gw = rand_word(); while (gw == m_secret);
            play_guess(gw, ended);
        end
        check("six_wrong_ended", 64'(ended), 64'(1));

        start_game("ROBOT");
        check("restart_state", 64'(state), 64'(ENTRY));
        check("restart_row", 64'(guess_row), 64'(0));
        check("restart_lose", 64'(lose), 64'(0));
        play_guess("ROBOT", ended);
        check("done_score_held", 64'(score), 64'(10'h2AA));
        press("A");
        check("done_key_ignored", 64'(letters), 64'("ROBOT"));

        // randomized games against the model
        for (int g = 0; g < 6; g++) begin
            start_game(rand_word());
            ended = 1'b0;
            guesses = 0;
            while (!ended && guesses < 6) begin
                gw = ($urandom_range(0, 3) == 0) ? m_secret : rand_word();
                play_guess(gw, ended);
                guesses++;
            end
            check($sformatf("game_%0d_ended", g), 64'(ended), 64'(1));
        end

`ifdef WORDLE_HARD_MODE_EN
        start_game("ROBOT");
        play_guess("RAINS", ended);
        type_word("TOAST");
        press(KEY_ENTER);
        check("hard_reject", 64'(reject), 64'(1));
        check("hard_state", 64'(state), 64'(ENTRY));
        check("hard_cursor", 64'(cursor), 64'(5));
        check("hard_letters", 64'(letters), 64'("TOAST"));
        tick();
        check("hard_reject_pulse", 64'(reject), 64'(0));
`endif

        // reset during the third yellow step
        do_reset();
        start_game("ROBOT");
        type_word("TORSO");
        press(KEY_ENTER);
        tick();
        tick();
        tick();
        check("mid_yellow_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_state", 64'(state), 64'(IDLE));
        check("mid_rst_score_valid", 64'(score_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_letters", 64'(letters), 64'(0));
        check("mid_rst_key_ready", 64'(key_ready), 64'(0));
        check("mid_rst_score", 64'(score), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wordle_guess_seq.md
Name: wordle_guess_seq

Overview:
- Sequences one Wordle game between the keyboard front end and the display/top FSM.
- Buffers keystrokes into a 5-letter guess with backspace and enter editing.
- On enter, scores the guess against the latched secret word, one letter per cycle (green/yellow/gray, duplicate-correct), and reports the result over a valid/ack handshake.
- Tracks rows 0-5 and declares win or lose.

Parameters:
WORD_LEN, 5, letters per guess (only 5 is supported)
MAX_GUESSES, 6, guess rows per game
LETTER_W, 8, ASCII bits per letter

Ports:
Clk  in  1  system clock
reset  in  1  synchronous, active-low reset (sampled on rising Clk; 0 = reset)
start  in  1  begin a game; latches secret_word
secret_word  in  40  5 ASCII letters; letter 0 in [39:32]
key_valid  in  1  keystroke available
key_code  in  8  ASCII keystroke
key_ready  out  1  keystroke accepted when key_valid && key_ready
letters  out  40  current guess buffer; letter 0 in [39:32]; empty slot = 8'h00
cursor  out  3  next free slot, 0..5
guess_row  out  3  current row, 0..5
score_valid  out  1  score is valid; held until ack
score  out  10  2 bits per letter; letter i in [9-2i:8-2i]; 00 gray, 01 yellow, 10 green
ack  in  1  consumer accepted the score
busy  out  1  high in GREEN or YELLOW
win  out  1  held in DONE
lose  out  1  held in DONE
reject  out  1  one-cycle pulse: enter refused (HARD_MODE_EN only; otherwise tied 0)

Behaviour:
- Reset (reset==0 at a Clk edge): state IDLE. All outputs 0, letters 0, secret 0, used mask 0. Reset wins over every other input, in any state.
- IDLE: start==1 -> latch secret_word, row 0, cursor 0, letters 0, go to ENTRY.
- ENTRY: key_ready=1. One accepted key per cycle.
  - 'a'-'z' are folded to 'A'-'Z'.
  - Letter with cursor<5: store at the cursor slot, cursor+1.
  - Letter with cursor==5: ignored.
  - 8'h08 (backspace) with cursor>0: cursor-1, clear that slot. At cursor 0: ignored.
  - 8'h0D (enter) with cursor==5: go to GREEN. With cursor<5: ignored.
  - Any other code: ignored. Ignored keys are still consumed.
- GREEN (1 cycle): compare all 5 positions in parallel. Set score=10 and used[i] where letter i == secret i; others 00.
- YELLOW (5 cycles, i=0..4): if letter i is not green, find the lowest secret index j with used[j]==0 and secret j == letter i. If found, score i=01 and set used[j].
- Latency: enter accepted at edge N -> score_valid=1 after edge N+6.
- REPORT: score_valid=1; score and letters stable.
  - ack (sampled only while score_valid=1), all green: go to DONE with win=1.
  - ack, not all green, row==5: go to DONE with lose=1.
  - ack otherwise: row+1, cursor 0, letters 0, score 0, used 0, go to ENTRY.
- DONE: win/lose and the last score are held. start -> same action as from IDLE, with win/lose cleared.
- start is ignored outside IDLE and DONE. key_valid is ignored outside ENTRY.

Optional Feature:
- Macro WORDLE_HARD_MODE_EN.
- Defined: a green mask and green letters accumulate across rows. Enter with cursor==5 is refused if any previously green position holds a different letter: stay in ENTRY, buffer unchanged, reject pulses for 1 cycle. Mask is cleared on start and on reset.
- Undefined: no extra registers; reject tied 0.

Decomposition:
- Package wordle_pkg holds:
  - state encoding (IDLE, ENTRY, GREEN, YELLOW, REPORT, DONE)
  - KEY_BS=8'h08, KEY_ENTER=8'h0D
  - SCORE_GRAY/YELLOW/GREEN
  - WORD_W=40
- Sub-module wordle_letter_match (combinational). Inputs: letter, secret, used mask. Outputs: hit, one-hot index of the lowest unused match.

Test Plan:
- Secret "ROBOT"; keys r,O,B,O,T,enter -> after 6 cycles score_valid=1, score=10'h2AA; ack -> win=1, lose=0, guess_row=0.
- Secret "ROBOT"; guess "TORSO" -> score=10'h191. Guess "OOOOO" -> score=10'h088 (duplicate O letters not double-counted).
- Keys A,B,BS,BS,BS -> cursor 2,1,0,0, letters=0. Then 6 letters -> cursor stays 5, sixth letter dropped. Enter with cursor 4 -> state unchanged.
- Six wrong guesses, ack each -> guess_row counts 0..5; after the 6th ack lose=1. start -> ENTRY, row 0, lose=0.
- reset=0 for one edge during the YELLOW cycle for i=2 -> next cycle IDLE, score_valid=0, busy=0, letters=0, key_ready=0.
- WORLE_HARD_MODE_EN defined, secret "ROBOT": row 0 "RAINS" (R green); row 1 "TOAST"+enter -> reject pulses 1 cycle, stays ENTRY, cursor 5.
